hex_keypad_scanner: RTL
=======================

// Module: hex_keypad_scanner
// PURPOSE
//  Input-side counterpart of the 8-digit seven-segment display driver. Scans a 4x4 hex keypad matrix
//  by driving one active-low column at a time and sampling the pulled-up rows. It debounces each
//  press, emits one pulse per press and shifts the hex code into a 32-bit value. That value feeds
//  the display's 32-bit number input directly (newest digit in [3:0]).
// PARAMETERS
//  CYCLE_PER_COL   100000  clk cycles each column is driven before rows are sampled (settling time)
//  DEBOUNCE_SCANS  4       consecutive identical samples required to accept a press/release (>=1)
// PORTS
//  clk        in   1   system clock
//  rstn       in   1   reset, synchronous, active-low
//  row_n      in   4   keypad rows, active-low (externally pulled up, synchronised outside this block)
//  col_n      out  4   keypad column drive, one-hot active-low
//  clear      in   1   synchronous clear of value
//  key_valid  out  1   1-cycle pulse: debounced press accepted
//  key_code   out  4   code of last accepted key = {row_idx[1:0], col_idx[1:0]}; held between pulses
//  value      out  32  shift register of entered digits, value = {value[27:0], key_code}
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): col_n=4'b1110, key_valid=0, key_code=0, value=0, state=SCAN,
//    tick counter=0, debounce counter=0, column index=0.
//  - Tick: a 30-bit counter runs 0..CYCLE_PER_COL-1 and wraps; "tick" = counter==CYCLE_PER_COL-1.
//    Rows are sampled only on tick; row_n is ignored on all other cycles.
//  - Row encode: the lowest-index low row wins (row_n=4'b0101 -> row_idx=1); 4'b1111 = no key.
//  - FSM (transitions on tick only, except the key_valid pulse):
//    SCAN:     no key -> advance column 1110->1101->1011->0111->1110; stay SCAN.
//              key -> latch row_n pattern and column; hold column; debounce counter=1; go DEBOUNCE.
//              If DEBOUNCE_SCANS==1, accept immediately (see DEBOUNCE accept).
//    DEBOUNCE: sample==latched pattern -> increment counter; on reaching DEBOUNCE_SCANS, accept:
//              key_code<={row_idx,col_idx}, value<={value[27:0],code}, key_valid=1 for the next
//              cycle only; go HELD with counter=0.
//              Mismatch (release or different row) -> advance to next column; go SCAN.
//    HELD:     column frozen; row_n==1111 increments counter, any low row resets it to 0;
//              at DEBOUNCE_SCANS -> advance column, go SCAN. Holding a key never repeats.
//  - Latency: key_valid rises 1 cycle after the tick carrying the DEBOUNCE_SCANS-th matching sample.
//    key_code and value update in that same cycle.
//  - Simultaneous clear and accept: clear wins (value=0). key_valid still pulses and key_code updates.
//  - Clear alone: value=0 the next cycle; FSM, col_n and key_code are unaffected.
//  - Second key pressed while HELD: ignored until all keys are released and debounced.
//  - Reset mid-debounce/held: return to reset values; no key_valid is emitted.
//  - value wraps naturally: the 9th digit shifts out value[31:28].
// STRUCTURE
//  - Shared package: FSM state encoding (SCAN, DEBOUNCE, HELD), COL_IDLE=4'b1111,
//    COL_FIRST=4'b1110, KEY_W=4, VALUE_W=32.
//  - One sub-module, keypad_row_encoder: combinational 4-bit active-low priority encoder
//    producing {hit, row_idx[1:0]}. All other logic stays in this module.
// TESTING (CYCLE_PER_COL=4, DEBOUNCE_SCANS=2)
//  1 Reset, no key for 32 cycles -> col_n cycles 1110,1101,1011,0111 every 4 clk; key_valid stays 0;
//    value=0.
//  2 Hold row_n=1101 while col_n=1011 for >=3 ticks -> one key_valid pulse, key_code=4'h6,
//    value=32'h6; col_n stays 1011 until release.
//  3 Bounce: row low for 1 tick, high next tick -> no key_valid; scanning resumes at the next column.
//  4 Enter keys 1,2,...,9 -> value=32'h23456789 after the 9th pulse (0x1 shifted out).
//  5 Hold key for 50 ticks, release, press again -> exactly 2 key_valid pulses.
//  6 Assert clear in the key_valid cycle -> value=0, key_code=new code. Pulse rstn mid-DEBOUNCE ->
//    all outputs at reset values and no pulse.

Source files
------------

// File: rtl/hex_keypad_scanner_pkg.sv
// Shared definitions for the hex keypad scanner: FSM encoding, column patterns and widths.
// Also holds a helper that turns a one-hot active-low column drive into its index.
package hex_keypad_scanner_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld
    } state_e;

    localparam logic [3:0] COL_IDLE  = 4'b1111;
    localparam logic [3:0] COL_FIRST = 4'b1110;
    localparam int unsigned KEY_W    = 4;
    localparam int unsigned VALUE_W  = 32;

    function automatic logic [1:0] col_index(input logic [3:0] col_n);
        logic [1:0] idx;
        case (col_n)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_encoder.sv
// Active-low 4-bit priority encoder: the lowest-index low row wins.
// hit_o is low when no row is pulled low.
module keypad_row_encoder (
    input  logic [3:0] row_n_i,
    output logic       hit_o,
    output logic [1:0] row_idx_o
);

    always_comb begin
        hit_o     = 1'b1;
        row_idx_o = 2'd0;
        if (!row_n_i[0]) begin
            row_idx_o = 2'd0;
        end else if (!row_n_i[1]) begin
            row_idx_o = 2'd1;
        end else if (!row_n_i[2]) begin
            row_idx_o = 2'd2;
        end else if (!row_n_i[3]) begin
            row_idx_o = 2'd3;
        end else begin
            hit_o = 1'b0;
        end
    end

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: drives one column at a time, debounces presses and releases,
// pulses key_valid_o once per press and shifts each code into a 32-bit digit value.
module hex_keypad_scanner
    import hex_keypad_scanner_pkg::*;
#(
    parameter int unsigned CYCLE_PER_COL  = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [3:0]         row_n_i,
    output logic [3:0]         col_n_o,
    input  logic               clear_i,
    output logic               key_valid_o,
    output logic [KEY_W-1:0]   key_code_o,
    output logic [VALUE_W-1:0] value_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CntW-1:0] DebTarget = CntW'(DEBOUNCE_SCANS);
    localparam logic [29:0] TickLast = 30'(CYCLE_PER_COL - 1);

    state_e             state_q, state_d;
    logic [29:0]        tick_cnt_q, tick_cnt_d;
    logic [3:0]         col_q, col_d;
    logic [3:0]         pat_q, pat_d;
    logic [CntW-1:0]    deb_cnt_q, deb_cnt_d;
    logic               key_valid_q, key_valid_d;
    logic [KEY_W-1:0]   key_code_q, key_code_d;
    logic [VALUE_W-1:0] value_q, value_d;

    logic            tick;
    logic            accept;
    logic            row_hit;
    logic [1:0]      row_idx;
    logic [3:0]      col_next;
    logic [CntW-1:0] deb_inc;
    logic [KEY_W-1:0] new_code;

    keypad_row_encoder u_row_enc (
        .row_n_i   (row_n_i),
        .hit_o     (row_hit),
        .row_idx_o (row_idx)
    );

    assign tick     = (tick_cnt_q == TickLast);
    assign col_next = {col_q[2:0], col_q[3]};
    assign deb_inc  = deb_cnt_q + 1'b1;
    assign new_code = {row_idx, col_index(col_q)};

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick ? 30'd0 : tick_cnt_q + 30'd1;
        col_d       = col_q;
        pat_d       = pat_q;
        deb_cnt_d   = deb_cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        value_d     = value_q;
        accept      = 1'b0;

        if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (row_hit) begin
                        pat_d     = row_n_i;
                        deb_cnt_d = CntW'(1);
                        if (DebTarget == CntW'(1)) begin
                            accept = 1'b1;
                        end else begin
                            state_d = StDebounce;
                        end
                    end else begin
                        col_d = col_next;
                    end
                end
                StDebounce: begin
                    if (row_n_i == pat_q) begin
                        deb_cnt_d = deb_inc;
                        if (deb_inc == DebTarget) begin
                            accept = 1'b1;
                        end
                    end else begin
                        col_d     = col_next;
                        deb_cnt_d = '0;
                        state_d   = StScan;
                    end
                end
                StHeld: begin
                    // Any low row restarts the release count, so a second key is ignored.
                    if (row_n_i != COL_IDLE) begin
                        deb_cnt_d = '0;
                    end else if (deb_inc == DebTarget) begin
                        deb_cnt_d = '0;
                        col_d     = col_next;
                        state_d   = StScan;
                    end else begin
                        deb_cnt_d = deb_inc;
                    end
                end
                default: state_d = StScan;
            endcase
        end

        if (accept) begin
            key_valid_d = 1'b1;
            key_code_d  = new_code;
            value_d     = {value_q[VALUE_W-KEY_W-1:0], new_code};
            deb_cnt_d   = '0;
            state_d     = StHeld;
        end

        if (clear_i) begin
            value_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StScan;
            tick_cnt_q  <= 30'd0;
            col_q       <= COL_FIRST;
            pat_q       <= COL_IDLE;
            deb_cnt_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            value_q     <= '0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            col_q       <= col_d;
            pat_q       <= pat_d;
            deb_cnt_q   <= deb_cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            value_q     <= value_d;
        end
    end

    assign col_n_o     = col_q;
    assign key_valid_o = key_valid_q;
    assign key_code_o  = key_code_q;
    assign value_o     = value_q;

endmodule
